// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: instruction formats, operation codes and the
// decoded packet that travels from the decoder into the FIFO.
package decode_queue_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    // TYPE_NONE is zero so a cleared packet reads as "no format"
    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J
    } inst_ty_t;

    typedef enum logic [5:0] {
        OPT_NOP = 6'd0,
        OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
        OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
        OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU,
        OPT_SB, OPT_SH, OPT_SW,
        OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
        OPT_SLLI, OPT_SRLI, OPT_SRAI,
        OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_OR, OPT_AND,
        OPT_SRL, OPT_SRA
    } inst_opt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    typedef struct packed {
        inst_ty_t  ty;
        inst_opt_t opt;
        reg_idx_t  rd;
        reg_idx_t  rs1;
        reg_idx_t  rs2;
        word_t     imm;
        logic      is_ls;
        logic      illegal;
    } dec_pkt_t;

endpackage

// File: rtl/decode_queue_inst_decode.sv
// Combinational RV32I decoder: raw word in, canonicalised packet out.
// Illegal words collapse to an all-zero packet with only the illegal flag set.
module decode_queue_inst_decode
    import decode_queue_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_pkt_t    o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    inst_ty_t   w_ty;
    inst_opt_t  w_opt;
    logic       w_ill;
    logic       w_is_ls;
    logic       w_shift;
    word_t      w_imm;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_f7  = i_inst[31:25];

    always_comb begin
        w_ty    = TYPE_NONE;
        w_opt   = OPT_NOP;
        w_ill   = FALSE;
        w_is_ls = FALSE;
        w_shift = FALSE;
        if (i_inst[1:0] != 2'b11) begin
            w_ill = TRUE;
        end else begin
            case (w_opc)
                OPC_LUI:   begin w_ty = TYPE_U; w_opt = OPT_LUI;   end
                OPC_AUIPC: begin w_ty = TYPE_U; w_opt = OPT_AUIPC; end
                OPC_JAL:   begin w_ty = TYPE_J; w_opt = OPT_JAL;   end
                OPC_JALR: begin
                    w_ty  = TYPE_I;
                    w_opt = OPT_JALR;
                    w_ill = (w_f3 != 3'd0);
                end
                OPC_BRANCH: begin
                    w_ty = TYPE_B;
                    case (w_f3)
                        3'd0:    w_opt = OPT_BEQ;
                        3'd1:    w_opt = OPT_BNE;
                        3'd4:    w_opt = OPT_BLT;
                        3'd5:    w_opt = OPT_BGE;
                        3'd6:    w_opt = OPT_BLTU;
                        3'd7:    w_opt = OPT_BGEU;
                        default: w_ill = TRUE;
                    endcase
                end
                OPC_LOAD: begin
                    w_ty    = TYPE_I;
                    w_is_ls = TRUE;
                    case (w_f3)
                        3'd0:    w_opt = OPT_LB;
                        3'd1:    w_opt = OPT_LH;
                        3'd2:    w_opt = OPT_LW;
                        3'd4:    w_opt = OPT_LBU;
                        3'd5:    w_opt = OPT_LHU;
                        default: w_ill = TRUE;
                    endcase
                end
                OPC_STORE: begin
                    w_ty    = TYPE_S;
                    w_is_ls = TRUE;
                    case (w_f3)
                        3'd0:    w_opt = OPT_SB;
                        3'd1:    w_opt = OPT_SH;
                        3'd2:    w_opt = OPT_SW;
                        default: w_ill = TRUE;
                    endcase
                end
                OPC_OPIMM: begin
                    w_ty = TYPE_I;
                    case (w_f3)
                        3'd0: w_opt = OPT_ADDI;
                        3'd2: w_opt = OPT_SLTI;
                        3'd3: w_opt = OPT_SLTIU;
                        3'd4: w_opt = OPT_XORI;
                        3'd6: w_opt = OPT_ORI;
                        3'd7: w_opt = OPT_ANDI;
                        3'd1: begin
                            w_shift = TRUE;
                            w_opt   = OPT_SLLI;
                            w_ill   = (w_f7 != 7'h00);
                        end
                        default: begin
                            w_shift = TRUE;
                            w_opt   = (w_f7 == 7'h20) ? OPT_SRAI : OPT_SRLI;
                            w_ill   = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                        end
                    endcase
                end
                OPC_OP: begin
                    w_ty = TYPE_R;
                    if (w_f7 == 7'h00) begin
                        case (w_f3)
                            3'd0:    w_opt = OPT_ADD;
                            3'd1:    w_opt = OPT_SLL;
                            3'd2:    w_opt = OPT_SLT;
                            3'd3:    w_opt = OPT_SLTU;
                            3'd4:    w_opt = OPT_XOR;
                            3'd5:    w_opt = OPT_SRL;
                            3'd6:    w_opt = OPT_OR;
                            default: w_opt = OPT_AND;
                        endcase
                    end else if (w_f7 == 7'h20 && w_f3 == 3'd0) begin
                        w_opt = OPT_SUB;
                    end else if (w_f7 == 7'h20 && w_f3 == 3'd5) begin
                        w_opt = OPT_SRA;
                    end else begin
                        w_ill = TRUE;
                    end
                end
                OPC_MISC: ;
                default: w_ill = TRUE;
            endcase
        end
        if (w_ill) begin
            w_ty    = TYPE_NONE;
            w_opt   = OPT_NOP;
            w_is_ls = FALSE;
            w_shift = FALSE;
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_ty)
            TYPE_I:  w_imm = w_shift ? {27'd0, i_inst[24:20]}
                                     : {{20{i_inst[31]}}, i_inst[31:20]};
            TYPE_S:  w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            TYPE_B:  w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                              i_inst[30:25], i_inst[11:8], 1'b0};
            TYPE_U:  w_imm = {i_inst[31:12], 12'd0};
            TYPE_J:  w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                              i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Fields a format does not use are forced to x0 so dispatch never sees false dependencies
    always_comb begin
        o_dec         = '0;
        o_dec.ty      = w_ty;
        o_dec.opt     = w_opt;
        o_dec.imm     = w_imm;
        o_dec.is_ls   = w_is_ls;
        o_dec.illegal = w_ill;
        o_dec.rd  = (w_ty inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J}) ? i_inst[11:7]  : 5'd0;
        o_dec.rs1 = (w_ty inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B}) ? i_inst[19:15] : 5'd0;
        o_dec.rs2 = (w_ty inside {TYPE_R, TYPE_S, TYPE_B})         ? i_inst[24:20] : 5'd0;
    end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: instructions are decoded on entry and held in a small FIFO
// between fetch and dispatch, with flush and a global rdy freeze.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int XLEN        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_inst,
    input  logic [XLEN-1:0]              in_pc,
    input  logic                         in_pred_taken,
    output logic                         out_valid,
    input  logic                         out_ready,
    output inst_ty_t                     out_ty,
    output inst_opt_t                    out_opt,
    output reg_idx_t                     out_rd,
    output reg_idx_t                     out_rs1,
    output reg_idx_t                     out_rs2,
    output logic [XLEN-1:0]              out_imm,
    output logic                         out_is_ls,
    output logic                         out_illegal,
    output logic [XLEN-1:0]              out_pc,
    output logic                         out_pred_taken,
    output logic [$clog2(QUEUE_DEPTH):0] count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    dec_pkt_t          r_mem      [QUEUE_DEPTH];
    logic [XLEN-1:0]   r_pc_mem   [QUEUE_DEPTH];
    logic              r_pred_mem [QUEUE_DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    dec_pkt_t          w_dec;
    dec_pkt_t          w_head;
    logic              w_push;
    logic              w_pop;

    decode_queue_inst_decode u_dec (
        .i_inst (in_inst[31:0]),
        .o_dec  (w_dec)
    );

    // Full blocks input even if the head pops this cycle: no pass-through of a freed slot
    assign in_ready  = rdy & ~flush & (r_count < CW'(QUEUE_DEPTH));
    assign out_valid = rdy & (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i]      <= '0;
                r_pc_mem[i]   <= '0;
                r_pred_mem[i] <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_tail]      <= w_dec;
                    r_pc_mem[r_tail]   <= in_pc;
                    r_pred_mem[r_tail] <= in_pred_taken;
                    r_tail             <= r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_head         = r_mem[r_head];
    assign out_ty         = w_head.ty;
    assign out_opt        = w_head.opt;
    assign out_rd         = w_head.rd;
    assign out_rs1        = w_head.rs1;
    assign out_rs2        = w_head.rs2;
    assign out_imm        = XLEN'(w_head.imm);
    assign out_is_ls      = w_head.is_ls;
    assign out_illegal    = w_head.illegal;
    assign out_pc         = r_pc_mem[r_head];
    assign out_pred_taken = r_pred_mem[r_head];
    assign count          = r_count;

endmodule
